// File: rtl/mem_dma_if.sv
// Control and memory-port signals of the block DMA initiator.
// master = the DMA engine; slave = the launching agent plus the memory it drives.
interface mem_dma_if #(
    parameter int Bits     = 16,
    parameter int AddrBits = 12
);
    logic                start;
    logic                mode;
    logic [AddrBits-1:0] src_addr;
    logic [AddrBits-1:0] dst_addr;
    logic [AddrBits:0]   count;
    logic [Bits-1:0]     fill_data;
    logic                busy;
    logic                done;
    logic                Read;
    logic                Write;
    logic [AddrBits-1:0] address;
    logic [Bits-1:0]     data_in;
    logic [Bits-1:0]     data_out;

    modport master (
        input  start, mode, src_addr, dst_addr, count, fill_data, data_out,
        output busy, done, Read, Write, address, data_in
    );

    modport slave (
        output start, mode, src_addr, dst_addr, count, fill_data, data_out,
        input  busy, done, Read, Write, address, data_in
    );
endinterface

// File: rtl/mem_dma.sv
// Block copy/fill engine on a single-port memory: copy = 2 cycles/word, fill = 1 cycle/word,
// done one cycle after the last write; no backpressure, the arbiter must hold the port while busy.
module mem_dma #(
    parameter int Bits     = 16,
    parameter int AddrBits = 12
) (
    input  logic     clk,
    input  logic     reset,
    mem_dma_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [AddrBits-1:0] src_ptr;
    logic [AddrBits-1:0] dst_ptr;
    logic [AddrBits:0]   rem;
    logic [Bits-1:0]     buf_dat;
    logic [Bits-1:0]     fill_dat;
    logic                mode_q;
    logic                launch;
    logic                last_wr;

    assign launch  = (state == S_IDLE) && bus.start;
    assign last_wr = (rem == (AddrBits + 1)'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        state_nxt = S_FIN;
                    end else if (bus.mode) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: state_nxt = S_WR;
            S_WR: begin
                if (last_wr) begin
                    state_nxt = S_FIN;
                end else if (mode_q) begin
                    state_nxt = S_WR;
                end else begin
                    state_nxt = S_RD;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pointers wrap naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            rem      <= '0;
            buf_dat  <= '0;
            fill_dat <= '0;
            mode_q   <= 1'b0;
        end else if (launch) begin
            src_ptr <= bus.src_addr;
            dst_ptr <= bus.dst_addr;
            rem     <= bus.count;
            mode_q  <= bus.mode;
            if (bus.mode) begin
                fill_dat <= bus.fill_data;
            end
        end else if (state == S_RD) begin
            buf_dat <= bus.data_out;
            src_ptr <= src_ptr + 1'b1;
        end else if (state == S_WR) begin
            dst_ptr <= dst_ptr + 1'b1;
            rem     <= rem - 1'b1;
        end
    end

    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        case (state)
            S_RD: begin
                bus.busy    = 1'b1;
                bus.Read    = 1'b1;
                bus.address = src_ptr;
            end
            S_WR: begin
                bus.busy    = 1'b1;
                bus.Write   = 1'b1;
                bus.address = dst_ptr;
                bus.data_in = mode_q ? fill_dat : buf_dat;
            end
            S_FIN:   bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_dma.sv
// Randomized bench for mem_dma: expected bus operations and final memory image come from
// a word-level model of copy/fill (ascending order, modulo address wrap).
module tb_mem_dma;
    localparam int Bits     = 16;
    localparam int AddrBits = 12;
    localparam int Depth    = 1 << AddrBits;

    typedef struct {
        bit                  rd;
        bit                  wr;
        logic [AddrBits-1:0] addr;
        logic [Bits-1:0]     dat;
    } op_t;

    logic clk = 1'b0;
    logic reset;

    mem_dma_if #(.Bits(Bits), .AddrBits(AddrBits)) bus ();

    mem_dma #(.Bits(Bits), .AddrBits(AddrBits)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [Bits-1:0] mem     [Depth];
    logic [Bits-1:0] ref_mem [Depth];
    logic [Bits-1:0] scratch [Depth];

    assign bus.data_out = mem[bus.address];

    always @(posedge clk) begin
        if (bus.Write) mem[bus.address] <= bus.data_in;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {bus.Read, bus.Write, bus.busy, bus.done};
    endfunction

    // Inputs wander after launch; the engine must ignore them.
    task automatic scramble_inputs();
        bus.mode      = 1'($urandom);
        bus.src_addr  = AddrBits'($urandom);
        bus.dst_addr  = AddrBits'($urandom);
        bus.count     = (AddrBits + 1)'($urandom);
        bus.fill_data = Bits'($urandom);
    endtask

    task automatic check_mem_image(input string tag);
        int diffs = 0;
        for (int i = 0; i < Depth; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check(tag, diffs, 0);
    endtask

    task automatic run_xfer(input bit md, input logic [AddrBits-1:0] src,
                            input logic [AddrBits-1:0] dst, input logic [AddrBits:0] cnt,
                            input logic [Bits-1:0] fill, input int poke_cyc, input int rst_cyc);
        op_t             ops[$];
        logic [Bits-1:0] v;
        logic [AddrBits-1:0] a;
        logic [AddrBits-1:0] d;
        for (int i = 0; i < Depth; i++) scratch[i] = ref_mem[i];
        for (int i = 0; i < int'(cnt); i++) begin
            a = src + AddrBits'(i);
            d = dst + AddrBits'(i);
            if (md) begin
                ops.push_back('{rd: 1'b0, wr: 1'b1, addr: d, dat: fill});
                scratch[d] = fill;
            end else begin
                v = scratch[a];
                ops.push_back('{rd: 1'b1, wr: 1'b0, addr: a, dat: '0});
                ops.push_back('{rd: 1'b0, wr: 1'b1, addr: d, dat: v});
                scratch[d] = v;
            end
        end

        bus.start     = 1'b1;
        bus.mode      = md;
        bus.src_addr  = src;
        bus.dst_addr  = dst;
        bus.count     = cnt;
        bus.fill_data = fill;
        tick();
        bus.start = 1'b0;
        scramble_inputs();

        for (int c = 1; c <= ops.size(); c++) begin
            check($sformatf("flags c%0d", c), flags(), {ops[c-1].rd, ops[c-1].wr, 1'b1, 1'b0});
            check($sformatf("addr c%0d", c), bus.address, ops[c-1].addr);
            if (ops[c-1].wr) begin
                check($sformatf("wdata c%0d", c), bus.data_in, ops[c-1].dat);
                ref_mem[ops[c-1].addr] = ops[c-1].dat;
            end
            if (c == rst_cyc) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst flags", flags(), 4'b0000);
                check("rst addr", bus.address, 0);
                check("rst wdata", bus.data_in, 0);
                for (int k = 0; k < 2 * int'(cnt); k++) begin
                    tick();
                    check("post-rst flags", flags(), 4'b0000);
                end
                check_mem_image("rst mem image");
                return;
            end
            if (c == poke_cyc) begin
                scramble_inputs();
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check("done flags", flags(), 4'b0001);
        check("done addr", bus.address, 0);
        check("done wdata", bus.data_in, 0);
        tick();
        check("idle flags", flags(), 4'b0000);
        check("idle addr", bus.address, 0);
        check_mem_image("mem image");
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) begin
            mem[i]     = Bits'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[12'h005] = 16'h200B; ref_mem[12'h005] = 16'h200B;
        mem[12'h006] = 16'h7200; ref_mem[12'h006] = 16'h7200;
        mem[12'h007] = 16'h7020; ref_mem[12'h007] = 16'h7020;

        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.count     = 13'd5;
        bus.fill_data = '0;
        tick();
        tick();
        check("reset flags", flags(), 4'b0000);
        check("reset addr", bus.address, 0);
        check("reset wdata", bus.data_in, 0);
        reset = 1'b0;

        // Copy 3 words
        run_xfer(1'b0, 12'h005, 12'h100, 13'd3, 16'h0000, 0, 0);
        check("copy w0", mem[12'h100], 16'h200B);
        check("copy w1", mem[12'h101], 16'h7200);
        check("copy w2", mem[12'h102], 16'h7020);

        // Fill across the top of the address space (also back-to-back launch)
        run_xfer(1'b1, 12'h000, 12'hFFE, 13'd4, 16'hA5A5, 0, 0);
        check("fill FFE", mem[12'hFFE], 16'hA5A5);
        check("fill FFF", mem[12'hFFF], 16'hA5A5);
        check("fill 000", mem[12'h000], 16'hA5A5);
        check("fill 001", mem[12'h001], 16'hA5A5);

        // Zero count, then start while busy, then reset mid-copy
        run_xfer(1'b0, 12'h123, 12'h456, 13'd0, 16'h0000, 0, 0);
        run_xfer(1'b0, 12'h020, 12'h300, 13'd2, 16'h0000, 2, 0);
        run_xfer(1'b0, 12'h040, 12'h400, 13'd4, 16'h0000, 0, 2);
        check("rst first dst", mem[12'h400], ref_mem[12'h040]);

        // Overlapping copy: ascending order propagates the first word
        run_xfer(1'b0, 12'h200, 12'h201, 13'd5, 16'h0000, 0, 0);
        check("overlap tail", mem[12'h205], mem[12'h200]);

        for (int t = 0; t < 30; t++) begin
            logic [AddrBits-1:0] s;
            logic [AddrBits-1:0] d;
            s = AddrBits'($urandom);
            d = AddrBits'($urandom);
            if ($urandom_range(0, 3) == 0) d = AddrBits'(Depth - $urandom_range(1, 8));
            run_xfer(1'($urandom), s, d, (AddrBits + 1)'($urandom_range(0, 20)),
                     Bits'($urandom), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_dma.md
# mem_dma

Memory-side bus initiator that moves blocks of words through the single-port memory interface (Read / Write / address / data) without involving the CPU datapath. It runs a block copy (read source word, write destination word) or a block fill (write a constant pattern) over a 12-bit word address space. It connects to the same memory port the CPU uses. An external arbiter grants the port to it while busy is high.

## Interface

Parameters:
- Bits, 16, memory word width.
- AddrBits, 12, memory address width. The count width is AddrBits+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  launch request, sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  AddrBits  first source address (copy only).
- dst_addr  input  AddrBits  first destination address.
- count  input  AddrBits+1  number of words, 0 to 4096.
- fill_data  input  Bits  pattern written in fill mode.
- busy  output  1  high in RD and WR states.
- done  output  1  one-cycle pulse when a transfer completes.
- Read  output  1  memory read strobe.
- Write  output  1  memory write strobe; memory commits on the clk edge while it is high.
- address  output  AddrBits  memory address.
- data_in  output  Bits  write data to memory.
- data_out  input  Bits  read data from memory; combinational, valid in the same cycle Read is high.

## Operation

- States: IDLE, RD, WR, FIN.
- IDLE with start=1 latches the following on that edge:
  - src_addr, dst_addr and count into internal pointers and the remaining-count register (rem);
  - mode;
  - fill_data, if mode=1.
- Next state from IDLE on start:
  - count=0 → FIN;
  - count≠0 and mode=0 → RD;
  - count≠0 and mode=1 → WR.
- RD:
  - Read=1, address=src pointer.
  - On the edge, data_out is captured into the word buffer and the src pointer increments.
  - Next state is WR.
- WR:
  - Write=1, address=dst pointer, data_in = buffer (copy) or latched fill_data (fill).
  - On the edge, the dst pointer increments and rem decrements.
  - If rem was 1, next state is FIN.
  - Otherwise next state is RD (copy) or WR (fill).
- FIN: done=1 for exactly one cycle, then IDLE.
- Read, Write, busy and done are decoded from the state register only (Moore outputs).
- Read and Write are never high in the same cycle.
- Pointer arithmetic is modulo 2^AddrBits: address 0xFFF increments to 0x000 with no error.
- Overlapping regions in copy mode are processed in ascending address order. Overlap is not corrected.
- start outside IDLE is ignored. Input changes after the launch edge have no effect.
- Outside RD/WR: address=0, data_in=0.

## Timing

- Reset values: state=IDLE, busy=0, done=0, Read=0, Write=0, address=0, data_in=0.
- The buffer, pointers and rem are cleared to 0 on reset.
- Reset has priority over every other input in every state.
- Reset mid-transfer behaves as follows:
  - a WR cycle coinciding with the reset edge still commits its word, because Write was high before the edge;
  - the cycle after reset shows Read=0, Write=0;
  - no done pulse is issued.
- Copy of N≥1 words, launch edge at cycle 0:
  - RD in cycles 1,3,…,2N−1;
  - WR in cycles 2,4,…,2N;
  - done=1 in cycle 2N+1;
  - IDLE in cycle 2N+2, where a new start is accepted.
- Fill of N≥1 words: WR in cycles 1..N, done in cycle N+1.
- count=0: done in cycle 1 with no Read or Write activity.
- Throughput: 1 word per 2 cycles (copy), 1 word per cycle (fill).

## Test plan

- Copy 3 words:
  - stimulus: memory preloaded with 0x005=0x200B, 0x006=0x7200, 0x007=0x7020; start with mode=0, src=0x005, dst=0x100, count=3;
  - required: Read/Write alternate over cycles 1–6, done pulses in cycle 7, and 0x100–0x102 hold 0x200B, 0x7200, 0x7020.
- Fill with wrap:
  - stimulus: mode=1, dst=0xFFE, count=4, fill_data=0xA5A5;
  - required: writes land on 0xFFE, 0xFFF, 0x000, 0x001, Write is high in cycles 1–4, and done is high in cycle 5.
- Zero count:
  - stimulus: start with count=0;
  - required: Read=Write=0 throughout, busy stays 0, done=1 in cycle 1.
- Start while busy:
  - stimulus: launch a copy with count=2, then pulse start with different addresses in cycle 2;
  - required: the transfer continues on the original addresses, only one done pulse occurs, at cycle 5.
- Reset mid-copy:
  - stimulus: copy with count=4, reset asserted at the end of cycle 2 (the first WR);
  - required: the first destination word is written, all later destinations are unchanged, cycle 3 shows all outputs at reset values, and no done pulse occurs.
- Back-to-back:
  - stimulus: a second start issued in the first IDLE cycle after done;
  - required: the second start is accepted and its first RD/WR appears the next cycle.
